// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter/router.
// Imported by rr_picker and bus_rr_arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ROUTE
  } state_t;

  localparam int ID_W_DEF = 8;

  // Compares only the low id_w bits, so callers can pass zero-extended IDs of any width up to 32.
  function automatic logic is_broadcast(input logic [31:0] dest,
                                        input logic [31:0] bcast,
                                        input int          id_w);
    logic [31:0] mask;
    mask = (id_w >= 32) ? '1 : ((32'd1 << id_w) - 32'd1);
    return (dest & mask) == (bcast & mask);
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the slot after
// 'last' sits at bit 0, priority-encode the lowest set bit, then un-rotate the index.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int DRVRS = 4,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic [DRVRS-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_req
);

  // One extra bit so enc + start (each < DRVRS) never overflows before the wrap.
  localparam int            CW = ID_W + 1;
  localparam logic [CW-1:0] N  = CW'(DRVRS);

  logic [CW-1:0]      nxt;
  logic [CW-1:0]      start;
  logic [2*DRVRS-1:0] dbl;
  logic [DRVRS-1:0]   rot;
  logic [CW-1:0]      enc;
  logic [CW-1:0]      sum;

  always_comb begin
    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned and no latch is inferred.
    nxt     = CW'(last) + CW'(1);
    start   = (nxt >= N) ? '0 : nxt;
    dbl     = {req, req};
    rot     = DRVRS'(dbl >> start);
    enc     = '0;
    any_req = |req;

    // Descending scan: the lowest set bit is written last and wins.
    for (int i = DRVRS - 1; i >= 0; i--) begin
      if (rot[i]) enc = CW'(i);
    end

    sum = enc + start;
    if (sum >= N) sum = sum - N;
    gnt_idx = ID_W'(sum);
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router for the shared terminal packet bus: grant, pop, route.
// Optional BUS_ARB_DROP_CNT_EN adds a saturating drop_cnt output for discarded packets.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 32,
  parameter int              ID_W      = ID_W_DEF,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DRVRS-1:0]   pndng,
  input  logic [PCKG_SZ-1:0] D_pop [DRVRS],
  output logic [DRVRS-1:0]   pop,
  output logic [DRVRS-1:0]   push,
  output logic [PCKG_SZ-1:0] D_push,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id
`ifdef BUS_ARB_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [PCKG_SZ-1:0] data_q;

  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [DRVRS-1:0]   gnt_oh;
  logic [DRVRS-1:0]   dest_oh;
  logic [DRVRS-1:0]   route_push;
  logic [PCKG_SZ-1:0] head_data;
  logic [ID_W-1:0]    head_dest;
  logic               head_pnd;

  rr_picker #(
    .DRVRS (DRVRS),
    .ID_W  (ID_W)
  ) u_picker (
    .req     (pndng),
    .last    (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // Head-of-FIFO view of the granted terminal and the push mask its packet would produce.
  always_comb begin
    gnt_oh    = '0;
    dest_oh   = '0;
    head_data = '0;
    for (int i = 0; i < DRVRS; i++) begin
      gnt_oh[i] = (grant_id == ID_W'(i));
      if (gnt_oh[i]) head_data = D_pop[i];
    end
    head_pnd  = |(pndng & gnt_oh);
    head_dest = head_data[PCKG_SZ-1 -: ID_W];
    for (int i = 0; i < DRVRS; i++) begin
      dest_oh[i] = (head_dest == ID_W'(i));
    end
    // Out-of-range IDs give an empty dest_oh; masking the source drops self-addressed packets.
    if (is_broadcast(32'(head_dest), 32'(BROADCAST), ID_W)) route_push = ~gnt_oh;
    else                                                     route_push = dest_oh & ~gnt_oh;
  end

  // pop follows pndng live during POP so a withdrawn request is never consumed.
  assign pop    = (state == POP) ? (pndng & gnt_oh) : '0;
  assign busy   = (state != IDLE);
  assign D_push = data_q;

  // The routing decision is taken on the capture edge, so push is a clean register during ROUTE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= ID_W'(DRVRS - 1);
      data_q   <= '0;
      push     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      push <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            rr_ptr   <= pick_idx;
            state    <= POP;
          end
        end
        POP: begin
          if (head_pnd) begin
            data_q <= head_data;
            push   <= route_push;
            state  <= ROUTE;
          end else begin
            state  <= IDLE;
          end
        end
        ROUTE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_ARB_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (state == ROUTE && push == '0 && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: stimulus queues expected pops/pushes,
// a negedge monitor pops and compares them whenever the DUT drives pop or push.
module tb_bus_rr_arbiter;

  localparam int DRVRS   = 4;
  localparam int PCKG_SZ = 32;
  localparam int ID_W    = 8;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic [DRVRS-1:0]   pndng = '0;
  logic [PCKG_SZ-1:0] D_pop [DRVRS] = '{default: '0};
  logic [DRVRS-1:0]   pop;
  logic [DRVRS-1:0]   push;
  logic [PCKG_SZ-1:0] D_push;
  logic               busy;
  logic [ID_W-1:0]    grant_id;
`ifdef BUS_ARB_DROP_CNT_EN
  logic [15:0]        drop_cnt;
`endif

  bus_rr_arbiter #(
    .DRVRS   (DRVRS),
    .PCKG_SZ (PCKG_SZ),
    .ID_W    (ID_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id)
`ifdef BUS_ARB_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DRVRS-1:0]   push;
    logic [PCKG_SZ-1:0] data;
  } push_exp_t;

  push_exp_t          exp_push_q[$];
  logic [DRVRS-1:0]   exp_pop_q[$];
  logic [PCKG_SZ-1:0] fifo [DRVRS][$];
  logic [DRVRS-1:0]   withdraw = '0;
  logic [DRVRS-1:0]   pop_seen = '0;
  int                 checks   = 0;
  int                 errors   = 0;
  int                 cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pop(input logic [DRVRS-1:0] p);
    exp_pop_q.push_back(p);
  endtask

  task automatic expect_push(input logic [DRVRS-1:0] p, input logic [PCKG_SZ-1:0] d);
    push_exp_t e;
    e.push = p;
    e.data = d;
    exp_push_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && !(busy == 1'b0 && pndng == '0 &&
                           exp_pop_q.size() == 0 && exp_push_q.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n >= budget), 64'(0));
  endtask

  task automatic wait_pop(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (pop == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n >= budget), 64'(0));
  endtask

  // Terminal FIFO model: consume heads popped last cycle, then present the new heads.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < DRVRS; i++) begin
      if (pop_seen[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
      pndng[i] = (fifo[i].size() != 0) && !withdraw[i];
      D_pop[i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every pop/push the DUT presents against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    pop_seen = reset ? '0 : pop;
    if (!reset) begin
      if (pop != '0) begin
        if (exp_pop_q.size() == 0) check("unexpected_pop", 64'(pop), 64'(0));
        else                       check("sb_pop", 64'(pop), 64'(exp_pop_q.pop_front()));
        check("pop_onehot", 64'($onehot(pop)), 64'(1));
      end
      if (push != '0) begin
        if (exp_push_q.size() == 0) begin
          check("unexpected_push", 64'(push), 64'(0));
        end else begin
          push_exp_t e;
          e = exp_push_q.pop_front();
          check("sb_push", 64'(push), 64'(e.push));
          check("sb_d_push", 64'(D_push), 64'(e.data));
        end
        check("pop_push_excl", 64'(pop), 64'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  logic [DRVRS-1:0] rr_push_tbl [DRVRS];
  logic [ID_W-1:0]  rr_dest_tbl [DRVRS];
  int               last_pop_cyc;

  initial begin
    rr_dest_tbl = '{8'h01, 8'h02, 8'h03, 8'h00};
    rr_push_tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pop", 64'(pop), 64'(0));
    check("rst_push", 64'(push), 64'(0));
    check("rst_d_push", 64'(D_push), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
`ifdef BUS_ARB_DROP_CNT_EN
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    reset = 1'b0;

    // Unicast 1 -> 2 with cycle-exact latency
    @(posedge clk);
    fifo[1].push_back(32'h0200ABCD);
    expect_pop(4'b0010);
    expect_push(4'b0100, 32'h0200ABCD);
    @(negedge clk);
    check("uni_n_busy", 64'(busy), 64'(0));
    check("uni_n_pop", 64'(pop), 64'(0));
    @(negedge clk);
    check("uni_n1_pop", 64'(pop), 64'(4'b0010));
    check("uni_n1_grant", 64'(grant_id), 64'(1));
    check("uni_n1_push", 64'(push), 64'(0));
    @(negedge clk);
    check("uni_n2_push", 64'(push), 64'(4'b0100));
    check("uni_n2_d_push", 64'(D_push), 64'(32'h0200ABCD));
    @(negedge clk);
    check("uni_n3_busy", 64'(busy), 64'(0));
    check("uni_n3_push", 64'(push), 64'(0));
    wait_idle("uni_idle", 20);

    // Broadcast from terminal 3
    @(posedge clk);
    fifo[3].push_back(32'hFF123456);
    expect_pop(4'b1000);
    expect_push(4'b0111, 32'hFF123456);
    wait_idle("bcast_idle", 20);

    // Round-robin: all four pending with four packets each
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DRVRS; i++) begin
        logic [PCKG_SZ-1:0] pkt;
        pkt = {rr_dest_tbl[i], 16'h0000, 8'(16 * i + k)};
        fifo[i].push_back(pkt);
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DRVRS; i++) begin
        expect_pop(4'(1 << i));
        expect_push(rr_push_tbl[i], {rr_dest_tbl[i], 16'h0000, 8'(16 * i + k)});
      end
    end
    last_pop_cyc = 0;
    for (int j = 0; j < 16; j++) begin
      wait_pop("rr_pop_timeout", 10);
      check("rr_grant", 64'(grant_id), 64'(j % 4));
      if (j > 0) check("rr_spacing", 64'(cyc - last_pop_cyc), 64'(3));
      last_pop_cyc = cyc;
    end
    wait_idle("rr_idle", 20);

    // Drops: out-of-range dest, then self-addressed dest
    @(posedge clk);
    fifo[0].push_back(32'h07000001);
    expect_pop(4'b0001);
    wait_idle("drop_oor_idle", 20);
    @(posedge clk);
    fifo[2].push_back(32'h02000002);
    expect_pop(4'b0100);
    wait_idle("drop_self_idle", 20);
`ifdef BUS_ARB_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'(2));
`endif

    // Withdrawal of terminal 2 during POP; terminal 3 is granted next
    @(posedge clk);
    fifo[2].push_back(32'h000000C2);
    @(negedge clk);
    check("wd_n_busy", 64'(busy), 64'(0));
    @(posedge clk);
    withdraw[2] = 1'b1;
    fifo[3].push_back(32'h010000D3);
    expect_pop(4'b1000);
    expect_push(4'b0010, 32'h010000D3);
    @(negedge clk);
    check("wd_no_pop", 64'(pop), 64'(0));
    check("wd_pop_busy", 64'(busy), 64'(1));
    check("wd_pop_grant", 64'(grant_id), 64'(2));
    @(negedge clk);
    check("wd_back_idle", 64'(busy), 64'(0));
    check("wd_no_push", 64'(push), 64'(0));
    @(negedge clk);
    check("wd_next_pop", 64'(pop), 64'(4'b1000));
    check("wd_next_grant", 64'(grant_id), 64'(3));
    wait_idle("wd_idle", 20);
    @(posedge clk);
    withdraw[2] = 1'b0;
    expect_pop(4'b0100);
    expect_push(4'b0001, 32'h000000C2);
    wait_idle("wd_resume_idle", 20);

    // Asynchronous reset while push is high
    @(posedge clk);
    fifo[1].push_back(32'h000000E1);
    expect_pop(4'b0010);
    expect_push(4'b0001, 32'h000000E1);
    @(negedge clk);
    @(negedge clk);
    check("rr_pre_pop", 64'(pop), 64'(4'b0010));
    @(negedge clk);
    check("rr_pre_push", 64'(push), 64'(4'b0001));
    #1;
    reset = 1'b1;
    #1;
    check("arst_push", 64'(push), 64'(0));
    check("arst_pop", 64'(pop), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_grant", 64'(grant_id), 64'(0));
    check("arst_d_push", 64'(D_push), 64'(0));
`ifdef BUS_ARB_DROP_CNT_EN
    check("arst_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    fifo[2].push_back(32'h010000F2);
    fifo[0].push_back(32'h030000F0);
    expect_pop(4'b0001);
    expect_push(4'b1000, 32'h030000F0);
    expect_pop(4'b0100);
    expect_push(4'b0010, 32'h010000F2);
    wait_pop("post_rst_pop_timeout", 10);
    check("post_rst_first_grant", 64'(grant_id), 64'(0));
    wait_idle("post_rst_idle", 20);

    check("sb_pop_drained", 64'(exp_pop_q.size()), 64'(0));
    check("sb_push_drained", 64'(exp_push_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter and router for the shared packet bus between DRVRS terminal FIFOs.
- Grants one pending terminal at a time and pops one packet from it.
- Decodes the destination ID in the packet's top ID_W bits.
- Pushes the packet to the destination terminal, or to all other terminals on broadcast.
- Sits between the per-terminal FIFO interfaces (pndng/pop/D_pop in, push/D_push out) and replaces the arbitration core of the bus generator.

Parameters:
- DRVRS, 4, number of terminals; valid range 2..255.
- PCKG_SZ, 32, packet width in bits; must be greater than ID_W.
- ID_W, 8, destination-ID field width, taken from bits [PCKG_SZ-1 -: ID_W].
- BROADCAST, {ID_W{1'b1}}, destination ID meaning all terminals except the source.

Ports:
- clk  in  1  bus clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- pndng  in  DRVRS  terminal i has a packet available; its data is on D_pop[i] (fall-through FIFO).
- D_pop  in  DRVRS x PCKG_SZ  head-of-FIFO data per terminal.
- pop  out  DRVRS  one-cycle pulse that consumes the head of terminal i.
- push  out  DRVRS  one-cycle write strobe into terminal i's receive FIFO.
- D_push  out  PCKG_SZ  shared routed data, valid when any push bit is high.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  ID_W  index of the currently granted terminal.

Behaviour:
- Reset values: pop=0, push=0, D_push=0, busy=0, grant_id=0, state=IDLE, rr_ptr=DRVRS-1 (so terminal 0 wins first).
- Reset is asynchronous. Asserting it mid-operation aborts immediately; no partial push or pop completes after it is asserted.
- FSM states: IDLE, POP, ROUTE.
- IDLE:
  - If |pndng, select the first set index scanning rr_ptr+1, rr_ptr+2, ... modulo DRVRS.
  - Register the result as grant_id, set rr_ptr to it, and go to POP.
  - Otherwise stay in IDLE.
- POP:
  - If pndng[grant_id]=1: pop[grant_id]=1 for exactly this cycle, D_pop[grant_id] is captured into data_q on this edge, and the FSM goes to ROUTE.
  - If pndng[grant_id] has dropped: no pop, return to IDLE. rr_ptr still advances.
- ROUTE: compute dest = data_q[PCKG_SZ-1 -: ID_W], drive D_push=data_q for this cycle only, then return to IDLE.
  - dest==BROADCAST: push = all ones except bit grant_id.
  - dest<DRVRS and dest!=grant_id: push = one-hot on dest.
  - Otherwise (out-of-range or self-addressed): push=0 and the packet is dropped.
- Outside ROUTE, D_push holds its last value; its content is don't-care when push=0.
- Latency: pndng sampled high in IDLE at cycle N, pop at N+1, push at N+2. Peak throughput is 1 packet per 3 cycles.
- Fairness: a terminal holding pndng continuously waits at most DRVRS-1 grants.
- pop and push are never high in the same cycle. At most one pop bit is ever high at a time.
- Packets are forwarded unmodified, including the ID field.

Optional Feature:
- Macro: BUS_ARB_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [15:0], reset to 0.
  - Increments by 1 on each ROUTE cycle that drops a packet; saturates at 16'hFFFF.
- Undefined: the port and counter are absent; drops are silent.

Decomposition:
- Package bus_arb_pkg holds:
  - enum state_t {IDLE, POP, ROUTE};
  - localparam ID_W_DEF=8;
  - function is_broadcast().
- Sub-module rr_picker (purely combinational):
  - Inputs: req[DRVRS], last[ID_W].
  - Outputs: gnt_idx and any_req.
  - Implemented as rotate, priority-encode, un-rotate; reused by the arbiter's IDLE logic.

Test Plan:
- Unicast: reset, pndng[1]=1, D_pop[1]=32'h02_00ABCD -> pop[1] pulses at N+1; push=4'b0100 and D_push=32'h0200ABCD at N+2; busy returns low at N+3.
- Broadcast: pndng[3]=1, D_pop[3]=32'hFF_123456 -> push=4'b0111 for one cycle with D_push=32'hFF123456.
- Round-robin: pndng=4'b1111 held, each FIFO holding 4 packets -> grant order 0,1,2,3,0,1,... with a pop every 3 cycles.
- Drops: dest=8'h07 from terminal 0, then a self-addressed dest=8'h02 from terminal 2 -> pop occurs, push stays 0 for both. With BUS_ARB_DROP_CNT_EN, drop_cnt=2.
- Withdrawal: pndng[2] drops during POP -> no pop and no push, FSM back to IDLE; the next grant goes to terminal 3 when it is pending.
- Reset mid-ROUTE: assert reset asynchronously while push is high -> push, pop and busy go to 0 immediately; after release, the first grant is terminal 0.
